vga_sync_decoder: RTL and testbench
===================================

Name: vga_sync_decoder

Overview:
- Receive end of the VGA timing bus: takes hs/vs/hblnk/vblnk from a timing source and rebuilds hcount/vcount for downstream consumers.
- Measures line and frame geometry, and declares lock after consecutive consistent frames.
- Sits after any stage that passes sync/blank but drops the counters, e.g. the board-level loopback check.
- Flags a sync error on any geometry change while locked.

Parameters:
H_ACTIVE, 1024, expected active pixels per line (hblnk low cycles)
V_ACTIVE, 768, expected active lines per frame (vblnk low lines)
LOCK_FRAMES, 2, consecutive good frames required to lock (1..7)

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
hs_in  in  1  horizontal sync, active high
vs_in  in  1  vertical sync, active high
hblnk_in  in  1  horizontal blank, high outside active pixels
vblnk_in  in  1  vertical blank, high outside active lines
hcount_out  out  11  recovered pixel counter
vcount_out  out  11  recovered line counter
hs_out, vs_out, hblnk_out, vblnk_out  out  1 each  inputs delayed one cycle, aligned with counters
h_total  out  11  cycles in last completed line
v_total  out  11  lines in last completed frame
frame_start  out  1  one-cycle pulse, cycle where vcount_out=0 and hcount_out=0
locked  out  1  geometry stable, counters valid
sync_err  out  1  one-cycle pulse on loss of lock

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, hblnk_q=0, vblnk_line_q=0, match_cnt=0, state SEARCH.
- Line-start event ls = hblnk_q & ~hblnk_in, where hblnk_q is the previous cycle's hblnk_in. The reset value of 0 blocks a spurious edge.
- Horizontal counting:
  - h_cnt <= 0 on ls, else h_cnt+1, saturating at 2047.
  - hcount_out = h_cnt, so the output equals the source hcount with exactly 1 cycle latency.
  - The *_out syncs are registered copies of the inputs and carry the same 1 cycle latency.
- Line events:
  - On ls: h_total <= h_cnt+1.
  - act_cnt counts cycles with hblnk_in low. Its value is checked against H_ACTIVE at ls, then cleared.
- Vertical counting, evaluated only on ls:
  - Frame-start event fs = ~vblnk_in & vblnk_line_q.
  - v_cnt <= 0 on fs, else v_cnt+1 (saturating at 2047).
  - vblnk_line_q <= vblnk_in.
  - vcount_out = v_cnt.
  - On fs: v_total <= v_cnt+1.
  - The count of lines with vblnk low is checked against V_ACTIVE, then cleared.
  - frame_start pulses in the cycle after fs, which is the first cycle with hcount_out=0, vcount_out=0.
- Frame-good flag frame_ok:
  - Set at fs.
  - Cleared on any ls where the line length differs from the first line length of the frame, or where act_cnt != H_ACTIVE.
  - Cleared at the next fs if active lines != V_ACTIVE.
- FSM:
  - SEARCH: on fs -> MEASURE, match_cnt=0. The frame just ended was partial and is discarded.
  - MEASURE, on fs:
    - If frame_ok and h_total/v_total equal the stored reference: match_cnt+1.
    - Otherwise: store the new reference and set match_cnt=0.
    - When match_cnt reaches LOCK_FRAMES -> LOCKED, and locked=1 from the next cycle.
  - LOCKED, any of the following -> SEARCH, locked=0, and sync_err pulses 1 cycle:
    - ls with line length != reference;
    - fs with v_total != reference;
    - h_cnt saturating at 2047, i.e. hblnk stuck.
- Counters keep running in every state. Values are meaningful only while locked=1.
- An ls and fs in the same cycle are one event: horizontal updates and vertical updates both apply.
- Reset mid-frame: immediate return to SEARCH, with no sync_err pulse.

Test Plan:
1. Source at 1024x768 geometry (lines of 1345 cycles, frames of 807 lines, hblnk from 1024, vblnk from 768) started with the decoder out of reset -> h_total=1345, v_total=807. locked rises 1 cycle after the 4th fs (SEARCH at 2nd frame start, matches at 3rd and 4th). Thereafter hcount_out/vcount_out equal the source counters delayed by 1 cycle.
2. Locked, then one line lengthened to 1346 cycles -> sync_err single pulse at that ls, locked=0. Relock 3 frame starts later.
3. Locked, then hblnk forced high -> sync_err when h_cnt reaches 2047, locked=0, hcount_out holds 2047.
4. Active width 1000 instead of H_ACTIVE -> locked never asserts over 10 frames, sync_err stays 0.
5. rst_n pulsed low mid-frame while locked -> outputs 0 asynchronously, no sync_err. Lock is reacquired as in scenario 1.
6. Check frame_start alignment -> exactly one pulse per frame, coincident with hcount_out=0, vcount_out=0, and period 1,085,415 cycles.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: rebuilds hcount/vcount from sync/blank inputs, measures
// line/frame geometry and locks after LOCK_FRAMES consecutive consistent frames.
module vga_sync_decoder #(
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [10:0] h_total,
    output logic [10:0] v_total,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_err
);
    localparam logic [10:0] CNT_MAX = '1;
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [2:0]  LOCK_N  = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state_q, state_d;

    logic        hblnk_q, vblnk_line_q;
    logic        hs_q, vs_q, hblnk_o_q, vblnk_o_q;
    logic [10:0] h_cnt_q, v_cnt_q, act_cnt_q, vact_cnt_q;
    logic [10:0] h_total_q, v_total_q, h_first_q;
    logic        frame_ok_q, first_pend_q, frame_start_q;
    logic [10:0] ref_h_q, ref_h_d, ref_v_q, ref_v_d;
    logic [2:0]  match_q, match_d;
    logic        sync_err_q, sync_err_d;
    logic        ls, fs, sat, line_ok, frame_good;
    logic [10:0] h_len, v_len;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == CNT_MAX) ? v : v + 11'd1;
    endfunction

    assign ls    = hblnk_q & ~hblnk_in;
    assign fs    = ls & ~vblnk_in & vblnk_line_q;
    assign h_len = sat_inc(h_cnt_q);
    assign v_len = sat_inc(v_cnt_q);
    // Flags the edge where h_cnt is about to pin at its maximum (hblnk stuck).
    assign sat   = ~ls & (h_cnt_q == CNT_MAX - 11'd1);

    assign line_ok    = (act_cnt_q == H_ACT) & (first_pend_q | (h_len == h_first_q));
    assign frame_good = frame_ok_q & line_ok & (vact_cnt_q == V_ACT);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hblnk_q       <= 1'b0;
            vblnk_line_q  <= 1'b0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hblnk_o_q     <= 1'b0;
            vblnk_o_q     <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            act_cnt_q     <= '0;
            vact_cnt_q    <= '0;
            h_total_q     <= '0;
            v_total_q     <= '0;
            h_first_q     <= '0;
            frame_ok_q    <= 1'b0;
            first_pend_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hblnk_q       <= hblnk_in;
            hs_q          <= hs_in;
            vs_q          <= vs_in;
            hblnk_o_q     <= hblnk_in;
            vblnk_o_q     <= vblnk_in;
            frame_start_q <= fs;
            if (ls) begin
                h_cnt_q      <= '0;
                h_total_q    <= h_len;
                act_cnt_q    <= 11'd1;
                vblnk_line_q <= vblnk_in;
                if (fs) begin
                    v_cnt_q      <= '0;
                    v_total_q    <= v_len;
                    vact_cnt_q   <= 11'd1;
                    frame_ok_q   <= 1'b1;
                    first_pend_q <= 1'b1;
                end else begin
                    v_cnt_q <= v_len;
                    if (!vblnk_in) vact_cnt_q <= sat_inc(vact_cnt_q);
                    if (first_pend_q) begin
                        h_first_q    <= h_len;
                        first_pend_q <= 1'b0;
                    end
                    if (!line_ok) frame_ok_q <= 1'b0;
                end
            end else begin
                h_cnt_q <= h_len;
                if (!hblnk_in) act_cnt_q <= sat_inc(act_cnt_q);
            end
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEARCH;
            match_q    <= '0;
            ref_h_q    <= '0;
            ref_v_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            ref_h_q    <= ref_h_d;
            ref_v_q    <= ref_v_d;
            sync_err_q <= sync_err_d;
        end
    end

    // The reference is kept across a loss of lock so a glitch relocks quickly.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        ref_h_d    = ref_h_q;
        ref_v_d    = ref_v_q;
        sync_err_d = 1'b0;
        case (state_q)
            SEARCH: begin
                if (fs) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end
            MEASURE: begin
                if (fs) begin
                    if (frame_good && h_len == ref_h_q && v_len == ref_v_q) begin
                        match_d = match_q + 3'd1;
                        if (match_q + 3'd1 >= LOCK_N) state_d = LOCKED;
                    end else begin
                        ref_h_d = h_len;
                        ref_v_d = v_len;
                        match_d = '0;
                    end
                end
            end
            LOCKED: begin
                if ((ls && h_len != ref_h_q) || (fs && v_len != ref_v_q) || sat) begin
                    state_d    = SEARCH;
                    match_d    = '0;
                    sync_err_d = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign hcount_out  = h_cnt_q;
    assign vcount_out  = v_cnt_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;
    assign hblnk_out   = hblnk_o_q;
    assign vblnk_out   = vblnk_o_q;
    assign h_total     = h_total_q;
    assign v_total     = v_total_q;
    assign frame_start = frame_start_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 16x8 geometry
// (22-cycle lines, 11-line frames) so whole frames fit in a short run.
module tb_vga_sync_decoder;
    localparam int H_ACT  = 16;
    localparam int V_ACT  = 8;
    localparam int LINE   = 22;
    localparam int V_TOT  = 11;
    localparam int FR     = LINE * V_TOT;

    logic        pclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        hs_in = 1'b0, vs_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [10:0] hcount_out, vcount_out, h_total, v_total;
    logic        hs_out, vs_out, hblnk_out, vblnk_out;
    logic        frame_start, locked, sync_err;

    vga_sync_decoder #(.H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .LOCK_FRAMES(2)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hs_in(hs_in), .vs_in(vs_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hs_out(hs_out), .vs_out(vs_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .h_total(h_total), .v_total(v_total),
        .frame_start(frame_start), .locked(locked), .sync_err(sync_err)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_err = 0;
    int src_h = 0, src_v = 0, act_w = H_ACT, long_v = -1;
    bit force_hb = 1'b0;
    int smp_h = 0, smp_v = 0;

    typedef struct {
        logic hs, vs, hb, vb;
        int   hc, vc, ht, vt;
        logic fst;
    } vec_t;
    vec_t tbl [11];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        hs_in    = (src_h >= 18 && src_h < 20);
        vs_in    = (src_v == 9);
        hblnk_in = force_hb || (src_h >= act_w);
        vblnk_in = (src_v >= V_ACT);
    endtask

    // One clock: sample point is 1 time unit after the edge; smp_* hold what the DUT just saw.
    task automatic tick();
        int len;
        @(posedge pclk);
        #1;
        smp_h = src_h;
        smp_v = src_v;
        len = (src_v == long_v) ? LINE + 1 : LINE;
        src_h++;
        if (src_h >= len) begin
            src_h = 0;
            if (src_v == long_v) long_v = -1;
            src_v = (src_v == V_TOT - 1) ? 0 : src_v + 1;
        end
        drive();
    endtask

    task automatic src_restart_reset();
        rst_n = 1'b0;
        src_h = 0; src_v = 0; long_v = -1; force_hb = 1'b0;
        drive();
        repeat (2) @(posedge pclk);
        #3 rst_n = 1'b1;
    endtask

    task automatic restart_and_lock(input string tag);
        int first = 0;
        int errs  = 0;
        src_restart_reset();
        for (int e = 1; e <= 6 * FR && first == 0; e++) begin
            tick();
            if (sync_err) errs++;
            if (locked && first == 0) first = e;
        end
        check({tag, "_lock_edge"}, first, 1 + 4 * FR);
        check({tag, "_h_total"}, h_total, LINE);
        check({tag, "_v_total"}, v_total, V_TOT);
        check({tag, "_no_err"}, errs, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 0, 0, 0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2, 0, 0, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 0, 0, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 4, 0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 4, 0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2, 1, 4, 0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3, 1, 4, 0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 4, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 2, 4, 0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2, 3, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 2, 3, 1'b0};

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_counters", int'(hcount_out | vcount_out | h_total | v_total), 0);
        check("rst_flags", int'({hs_out, vs_out, hblnk_out, vblnk_out, frame_start, locked, sync_err}), 0);
        #2 rst_n = 1'b1;

        // Hand-computed short waveform straight out of reset
        for (int i = 0; i < 11; i++) begin
            hs_in = tbl[i].hs; vs_in = tbl[i].vs; hblnk_in = tbl[i].hb; vblnk_in = tbl[i].vb;
            @(posedge pclk);
            #1;
            check($sformatf("tbl%0d_hcount", i), hcount_out, tbl[i].hc);
            check($sformatf("tbl%0d_vcount", i), vcount_out, tbl[i].vc);
            check($sformatf("tbl%0d_h_total", i), h_total, tbl[i].ht);
            check($sformatf("tbl%0d_v_total", i), v_total, tbl[i].vt);
            check($sformatf("tbl%0d_frame_start", i), frame_start, tbl[i].fst);
            check($sformatf("tbl%0d_syncs", i), {hs_out, vs_out, hblnk_out, vblnk_out},
                  {tbl[i].hs, tbl[i].vs, tbl[i].hb, tbl[i].vb});
        end

        // Scenario 1: acquire lock
        restart_and_lock("s1");

        // Scenario 6: counter tracking and frame_start alignment/period
        begin
            int pulses = 0, bad_align = 0, bad_trk = 0, bad_period = 0, last = -1, lost = 0;
            for (int c = 0; c < 3 * FR; c++) begin
                tick();
                if (hcount_out != smp_h || vcount_out != smp_v) bad_trk++;
                if (frame_start != (smp_h == 0 && smp_v == 0)) bad_align++;
                if (frame_start) begin
                    pulses++;
                    if (hcount_out != 0 || vcount_out != 0) bad_align++;
                    if (last >= 0 && c - last != FR) bad_period++;
                    last = c;
                end
                if (!locked) lost++;
            end
            check("s6_track", bad_trk, 0);
            check("s6_fs_pulses", pulses, 3);
            check("s6_fs_align", bad_align, 0);
            check("s6_fs_period", bad_period, 0);
            check("s6_stay_locked", lost, 0);
        end

        // Scenario 2: one long line while locked, then relock
        begin
            int errs = 0, err_h = -1, err_v = -1, err_lk = -1, fsn = 0, relock_fs = 0;
            check("s2_locked_before", locked, 1);
            long_v = 3;
            for (int c = 0; c < 5 * FR && relock_fs == 0; c++) begin
                tick();
                if (errs > 0 && frame_start) fsn++;
                if (errs > 0 && locked && relock_fs == 0) relock_fs = fsn;
                if (sync_err) begin
                    if (errs == 0) begin err_h = smp_h; err_v = smp_v; err_lk = locked; end
                    errs++;
                end
            end
            check("s2_err_count", errs, 1);
            check("s2_err_at_h", err_h, 0);
            check("s2_err_at_v", err_v, 4);
            check("s2_err_locked", err_lk, 0);
            check("s2_relock_fs", relock_fs, 3);
        end

        // Scenario 3: hblnk stuck high while locked
        begin
            int errs = 0, err_hc = -1, err_lk = -1, more = 0;
            check("s3_locked_before", locked, 1);
            force_hb = 1'b1;
            drive();
            for (int c = 0; c < 2200 && errs == 0; c++) begin
                tick();
                if (sync_err) begin errs++; err_hc = hcount_out; err_lk = locked; end
            end
            for (int c = 0; c < 10; c++) begin
                tick();
                if (sync_err) more++;
            end
            check("s3_err_seen", errs, 1);
            check("s3_err_hcount", err_hc, 2047);
            check("s3_err_locked", err_lk, 0);
            check("s3_hold_2047", hcount_out, 2047);
            check("s3_single_pulse", more, 0);
            force_hb = 1'b0;
        end

        // Scenario 4: wrong active width never locks
        begin
            int lk = 0, errs = 0;
            act_w = H_ACT - 1;
            src_restart_reset();
            for (int c = 0; c < 10 * FR; c++) begin
                tick();
                if (locked) lk++;
                if (sync_err) errs++;
            end
            check("s4_never_locked", lk, 0);
            check("s4_no_err", errs, 0);
            check("s4_h_total", h_total, LINE);
            act_w = H_ACT;
        end

        // Scenario 5: asynchronous reset mid-frame while locked
        begin
            int errs = 0;
            restart_and_lock("s5a");
            repeat (100) tick();
            check("s5_locked_before", locked, 1);
            #3 rst_n = 1'b0;
            #1;
            check("s5_async_counters", int'(hcount_out | vcount_out | h_total | v_total), 0);
            check("s5_async_flags", int'({hs_out, vs_out, hblnk_out, vblnk_out, frame_start, locked, sync_err}), 0);
            for (int c = 0; c < 3; c++) begin
                @(posedge pclk);
                #1;
                if (sync_err) errs++;
            end
            check("s5_no_err_in_reset", errs, 0);
            restart_and_lock("s5b");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
